// File: rtl/scd_pkg.sv
// Shared types for the bit-serial adder: the controller state encoding.
package scd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/FullAdder.sv
// One-bit full adder shared by the serial datapath.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one FullAdder plus a carry flop, LSB first,
// valid/ready on both the operand and the result side.
module serial_adder
  import scd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  // One extra bit keeps WIDTH=1 and power-of-2 widths from aliasing the terminal count.
  localparam int             CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic             fa_sum_s;
  logic             fa_cout_s;
  logic [WIDTH:0]   sum_next_s;

  assign bus.in_ready  = (state_r == IDLE) | ((state_r == DONE) & bus.out_ready);
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;

  // New sum bit enters at the MSB so the LSB-first stream lands in order.
  assign sum_next_s = {fa_sum_s, sum_sh_r};

  FullAdder u_fa (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  // Controller, shift registers, carry and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      sum_sh_r    <= '0;
      carry_r     <= 1'b0;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.b;
            carry_r <= bus.cin;
            cnt_r   <= '0;
            state_r <= RUN;
          end
        end
        RUN: begin
          sum_sh_r <= sum_next_s[WIDTH:1];
          carry_r  <= fa_cout_s;
          a_sh_r   <= a_sh_r >> 1;
          b_sh_r   <= b_sh_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == CNT_LAST) begin
            sum_r       <= sum_next_s[WIDTH:1];
            cout_r      <= fa_cout_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (bus.in_valid) begin
              a_sh_r  <= bus.a;
              b_sh_r  <= bus.b;
              carry_r <= bus.cin;
              cnt_r   <= '0;
              state_r <= RUN;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule
